// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: per-slot blanking, per-digit enable and
// decimal point, and a staging/shadow register pair that updates only at frame boundaries.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SEL_W        = 3,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [SEL_W-1:0]        digit_sel,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [4*NUM_DIGITS-1:0] stg_dig_q, stg_dig_d, shd_dig_q, shd_dig_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0]   stg_en_q, stg_en_d, shd_en_q, shd_en_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;
  logic                    boundary;
  logic                    show;
  logic [3:0]              nibble;

  assign boundary = (cnt_q == '0) && (sel_q == '0);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    cnt_d     = cnt_q + CNT_W'(1);
    sel_d     = sel_q;
    stg_dig_d = stg_dig_q;
    stg_dp_d  = stg_dp_q;
    stg_en_d  = stg_en_q;
    shd_dig_d = shd_dig_q;
    shd_dp_d  = shd_dp_q;
    shd_en_d  = shd_en_q;
    pending_d = pending_q;

    if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
      sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
    end

    // The copy reads the pre-load staging value, so a load in the boundary cycle waits a frame.
    if (boundary && pending_q) begin
      shd_dig_d = stg_dig_q;
      shd_dp_d  = stg_dp_q;
      shd_en_d  = stg_en_q;
      pending_d = 1'b0;
    end
    if (load) begin
      stg_dig_d = digits_in;
      stg_dp_d  = dp_in;
      stg_en_d  = en_mask;
      pending_d = 1'b1;
    end

    // Outputs are derived from next-state values so they line up with cnt/digit_sel.
    nibble = shd_dig_d[4*sel_d +: 4];
    show   = (cnt_d >= BLANK_END) && shd_en_d[sel_d];
    an_d   = '1;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (show) begin
      an_d  = ~(NUM_DIGITS'(1) << sel_d);
      seg_d = hex_to_seg(nibble);
      dp_d  = ~shd_dp_d[sel_d];
    end
    tick_d = (cnt_d == '0) && (sel_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      sel_q     <= '0;
      stg_dig_q <= '0;
      stg_dp_q  <= '0;
      stg_en_q  <= '0;
      shd_dig_q <= '0;
      shd_dp_q  <= '0;
      shd_en_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      stg_dig_q <= stg_dig_d;
      stg_dp_q  <= stg_dp_d;
      stg_en_q  <= stg_en_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      shd_en_q  <= shd_en_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_sel  = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (4 digits, 8-clock slots, 2-clock blank) against a
// cycle-count reference model of the scan timing and staging/shadow update rules.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .SEL_W(2), .DIGIT_CYCLES(8), .BLANK_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .en_mask(en_mask), .an(an), .seg(seg), .dp(dp), .digit_sel(digit_sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: m_t counts clocks since reset release; slot/digit derive from it.
  int          m_t = 0;
  logic [15:0] m_stg_dig = '0, m_shd_dig = '0;
  logic [3:0]  m_stg_dp = '0, m_shd_dp = '0, m_stg_en = '0, m_shd_en = '0;
  logic        m_pend = 1'b0;

  function automatic int m_cnt();
    return m_t % 8;
  endfunction

  function automatic int m_sel();
    return (m_t / 8) % 4;
  endfunction

  // Expected {an, seg, dp, digit_sel, frame_tick}.
  function automatic logic [14:0] m_exp();
    int   c = m_cnt();
    int   s = m_sel();
    logic lit = (c >= 2) && m_shd_en[s];
    logic [15:0] dg = m_shd_dig;
    logic [3:0]  a = lit ? ~(4'b0001 << s) : 4'hF;
    logic [6:0]  g = lit ? dec[(dg >> (4 * s)) & 16'hF] : 7'h7F;
    logic        p = lit ? ~m_shd_dp[s] : 1'b1;
    logic        t = (c == 0) && (s == 0) && (m_t != 0);
    return {a, g, p, 2'(s), t};
  endfunction

  task automatic cyc(input logic r, input logic l, input logic [15:0] d,
                     input logic [3:0] p, input logic [3:0] e);
    rst = r; load = l; digits_in = d; dp_in = p; en_mask = e;
    @(posedge clk);
    if (r) begin
      m_t = 0; m_pend = 0;
      m_stg_dig = '0; m_stg_dp = '0; m_stg_en = '0;
      m_shd_dig = '0; m_shd_dp = '0; m_shd_en = '0;
    end else begin
      if (m_cnt() == 0 && m_sel() == 0 && m_pend) begin
        m_shd_dig = m_stg_dig; m_shd_dp = m_stg_dp; m_shd_en = m_stg_en; m_pend = 0;
      end
      if (l) begin
        m_stg_dig = d; m_stg_dp = p; m_stg_en = e; m_pend = 1;
      end
      m_t++;
    end
    #1;
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic go_to(input int s, input int c, input string tag);
    for (int k = 0; k < 64; k++) begin
      if (m_sel() == s && m_cnt() == c) return;
      cyc(0, 0, '0, '0, '0);
    end
    if (!(m_sel() == s && m_cnt() == c)) begin
      n_cmp++; n_err++;
      $display("FAIL %s: slot %0d/%0d not reached, at %0d/%0d", tag, s, c, m_sel(), m_cnt());
    end
  endtask

  task automatic test_reset();
    int last = -1;
    int ticks = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, '0, '0, '0);
      n_cmp++;
      if ({an, seg, dp, digit_sel, frame_tick} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_hold: got an=%h seg=%h dp=%b sel=%0d tick=%b, want F 7f 1 0 0",
                 an, seg, dp, digit_sel, frame_tick);
      end
    end
    for (int i = 0; i < 96; i++) begin
      if (i > 0) cyc(0, 0, '0, '0, '0);
      n_cmp++;
      if ({an, seg, dp, digit_sel, frame_tick} !== m_exp()) begin
        n_err++;
        $display("FAIL reset_model t=%0d: got %h want %h", m_t,
                 {an, seg, dp, digit_sel, frame_tick}, m_exp());
      end
      n_cmp++;
      if (an !== 4'hF) begin
        n_err++;
        $display("FAIL reset_dark t=%0d: an got %h want f", m_t, an);
      end
      if (frame_tick) begin
        if (last >= 0) begin
          n_cmp++;
          if (m_t - last != 32) begin
            n_err++;
            $display("FAIL reset_tick_period: got %0d want 32", m_t - last);
          end
        end
        last = m_t;
        ticks++;
      end
    end
    cyc(0, 0, '0, '0, '0);
    if (frame_tick) ticks++;
    n_cmp++;
    if (ticks != 3) begin
      n_err++;
      $display("FAIL reset_tick_count: got %0d want 3", ticks);
    end
  endtask

  task automatic test_load();
    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    go_to(3, 5, "load");
    cyc(0, 1, 16'h1234, 4'b0100, 4'hF);
    go_to(0, 0, "load");
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, '0, '0, '0);
      n_cmp++;
      if ({an, seg, dp, digit_sel, frame_tick} !== m_exp()) begin
        n_err++;
        $display("FAIL load_model t=%0d: got %h want %h", m_t,
                 {an, seg, dp, digit_sel, frame_tick}, m_exp());
      end
      if (m_cnt() < 2) begin
        n_cmp++;
        if (an !== 4'hF) begin
          n_err++;
          $display("FAIL load_blank slot %0d: an got %h want f", m_sel(), an);
        end
      end else if (m_cnt() == 5) begin
        n_cmp++;
        if ({an, seg, dp} !== {exp_an[m_sel()], exp_seg[m_sel()], exp_dp[m_sel()]}) begin
          n_err++;
          $display("FAIL load_show slot %0d: got %h/%h/%b want %h/%h/%b", m_sel(), an, seg, dp,
                   exp_an[m_sel()], exp_seg[m_sel()], exp_dp[m_sel()]);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    logic [6:0] old_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] new_seg [4] = '{7'h21, 7'h46, 7'h03, 7'h08};
    int f = 0;
    go_to(2, 3, "tear");
    cyc(0, 1, 16'hABCD, 4'h0, 4'hF);
    for (int i = 0; i < 44; i++) begin
      cyc(0, 0, '0, '0, '0);
      if (m_cnt() == 0 && m_sel() == 0) f++;
      n_cmp++;
      if ({an, seg, dp, digit_sel, frame_tick} !== m_exp()) begin
        n_err++;
        $display("FAIL tear_model t=%0d: got %h want %h", m_t,
                 {an, seg, dp, digit_sel, frame_tick}, m_exp());
      end
      if (m_cnt() == 5) begin
        n_cmp++;
        if (seg !== (f == 0 ? old_seg[m_sel()] : new_seg[m_sel()])) begin
          n_err++;
          $display("FAIL tear_seg frame %0d slot %0d: got %h want %h", f, m_sel(), seg,
                   f == 0 ? old_seg[m_sel()] : new_seg[m_sel()]);
        end
      end
    end
  endtask

  task automatic test_mask();
    int last = -1;
    go_to(3, 0, "mask");
    cyc(0, 1, 16'($urandom), 4'($urandom), 4'b1010);
    go_to(0, 0, "mask");
    for (int i = 0; i < 64; i++) begin
      cyc(0, 0, '0, '0, '0);
      n_cmp++;
      if ({an, seg, dp, digit_sel, frame_tick} !== m_exp()) begin
        n_err++;
        $display("FAIL mask_model t=%0d: got %h want %h", m_t,
                 {an, seg, dp, digit_sel, frame_tick}, m_exp());
      end
      if (m_sel() == 0 || m_sel() == 2) begin
        n_cmp++;
        if (an !== 4'hF) begin
          n_err++;
          $display("FAIL mask_off slot %0d: an got %h want f", m_sel(), an);
        end
      end else if (m_cnt() >= 2) begin
        n_cmp++;
        if (an !== ~(4'b0001 << m_sel())) begin
          n_err++;
          $display("FAIL mask_on slot %0d: an got %h want %h", m_sel(), an, ~(4'b0001 << m_sel()));
        end
      end
      if (frame_tick) begin
        if (last >= 0) begin
          n_cmp++;
          if (m_t - last != 32) begin
            n_err++;
            $display("FAIL mask_period: got %0d want 32", m_t - last);
          end
        end
        last = m_t;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] v = 16'($urandom);
    int f = 0;
    go_to(3, 2, "simul");
    cyc(0, 1, 16'h1111, 4'h0, 4'hF);
    go_to(0, 0, "simul");
    n_cmp++;
    if (frame_tick !== 1'b1) begin
      n_err++;
      $display("FAIL simul_tick: got %b want 1", frame_tick);
    end
    cyc(0, 1, v, 4'h0, 4'hF);
    for (int i = 0; i < 63; i++) begin
      cyc(0, 0, '0, '0, '0);
      if (m_cnt() == 0 && m_sel() == 0) f++;
      n_cmp++;
      if ({an, seg, dp, digit_sel, frame_tick} !== m_exp()) begin
        n_err++;
        $display("FAIL simul_model t=%0d: got %h want %h", m_t,
                 {an, seg, dp, digit_sel, frame_tick}, m_exp());
      end
      if (m_cnt() == 5 && f < 2) begin
        n_cmp++;
        if (seg !== (f == 0 ? 7'h79 : dec[(v >> (4 * m_sel())) & 16'hF])) begin
          n_err++;
          $display("FAIL simul_seg frame %0d slot %0d: got %h want %h", f, m_sel(), seg,
                   f == 0 ? 7'h79 : dec[(v >> (4 * m_sel())) & 16'hF]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) == 0),
          16'($urandom), 4'($urandom), 4'($urandom));
      n_cmp++;
      if ({an, seg, dp, digit_sel, frame_tick} !== m_exp()) begin
        n_err++;
        $display("FAIL random_model t=%0d: got %h want %h", m_t,
                 {an, seg, dp, digit_sel, frame_tick}, m_exp());
      end
    end
  endtask

  task automatic test_reset_mid();
    go_to(0, 0, "rstmid");
    cyc(0, 1, 16'($urandom), 4'($urandom), 4'hF);
    go_to(1, 3, "rstmid");
    cyc(0, 1, 16'($urandom), 4'($urandom), 4'hF);
    go_to(1, 5, "rstmid");
    cyc(1, 0, '0, '0, '0);
    n_cmp++;
    if ({an, digit_sel, frame_tick} !== {4'hF, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL rstmid_after: got an=%h sel=%0d tick=%b want f 0 0", an, digit_sel, frame_tick);
    end
    for (int i = 0; i < 80; i++) begin
      cyc(0, 0, '0, '0, '0);
      n_cmp++;
      if (an !== 4'hF || {an, seg, dp, digit_sel, frame_tick} !== m_exp()) begin
        n_err++;
        $display("FAIL rstmid_dark t=%0d: got %h want %h", m_t,
                 {an, seg, dp, digit_sel, frame_tick}, m_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_tear_free();
    test_mask();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment display controller. It time-multiplexes NUM_DIGITS hex digits onto one shared active-low segment bus and a one-hot active-low anode bus. Each digit slot starts with a programmable anti-ghosting blank interval. It adds per-digit enable, decimal points, and tear-free frame-synchronous updates through a staging/shadow register pair. It replaces the fixed 8:1 anode select and sits between the datapath's display registers and the board's anode/segment pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (2..16)
SEL_W, 3, width of digit_sel; must satisfy 2**SEL_W >= NUM_DIGITS
DIGIT_CYCLES, 100000, clocks per digit slot (1 kHz slot rate at 100 MHz)
BLANK_CYCLES, 1000, clocks at the start of each slot with all anodes off; 1 <= BLANK_CYCLES < DIGIT_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load  in  1  one-clock strobe; captures digits_in/dp_in/en_mask into staging
digits_in  in  4*NUM_DIGITS  hex nibbles; digit i = digits_in[4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
en_mask  in  NUM_DIGITS  digit enable, 1 = displayed
an  out  NUM_DIGITS  anodes, active-low, at most one low
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
digit_sel  out  SEL_W  index of the current slot
frame_tick  out  1  one-clock pulse at each frame boundary

Behaviour:
- Single clock domain; reset is synchronous and active-high. All state and outputs change only on the rising edge of clk.
- Reset values: an all 1, seg 7'h7F, dp 1, digit_sel 0, frame_tick 0, slot counter cnt 0, staging and shadow registers 0 (all digits disabled, display dark), pending 0.
- Slot counter: cnt counts 0..DIGIT_CYCLES-1.
  - When cnt = DIGIT_CYCLES-1, cnt wraps to 0 and digit_sel advances.
  - digit_sel wraps from NUM_DIGITS-1 to 0.
  - The first cycle after reset release is cnt=0, digit_sel=0.
- Outputs are registers computed from next-state values, so they align with the current cnt/digit_sel (no added latency).
  - BLANK phase (cnt < BLANK_CYCLES): an all 1, seg 7'h7F, dp 1.
  - SHOW phase (cnt >= BLANK_CYCLES) with shadow_en[digit_sel]=1: an[digit_sel]=0, all other anodes 1; seg = decode(shadow nibble); dp = ~shadow_dp[digit_sel].
  - SHOW phase with shadow_en[digit_sel]=0: same as BLANK. Slot timing is unchanged for disabled digits.
- Decode table (hex, active-low, gfedcba):
  0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Load path:
  - load=1 captures all three inputs into staging and sets pending.
  - Back-to-back loads overwrite staging; last one wins.
- Frame boundary is the cycle with cnt=0 and digit_sel=0.
  - frame_tick=1 in that cycle, every frame.
  - If pending was set before the boundary, staging is copied to shadow at the boundary edge, so new data is visible from digit 0 of that frame. Pending then clears.
- Simultaneous load and boundary:
  - The copy uses the staging contents from before the load.
  - The newly loaded data lands in staging, and pending stays 1.
  - The new data appears one frame later.
- Shadow never changes mid-frame, so a displayed frame never mixes old and new data.
- rst mid-frame: all registers return to reset values on the next edge, pending data is discarded, and the display is dark until the next load plus frame boundary.

Test Plan:
All scenarios use NUM_DIGITS=4, SEL_W=2, DIGIT_CYCLES=8, BLANK_CYCLES=2.
1. Reset: hold rst 3 clocks -> an=4'hF, seg=7'h7F, dp=1, digit_sel=0, frame_tick=0. Release with no load -> an stays 4'hF for 3 full frames; frame_tick pulses every 32 clocks.
2. Load digits_in=16'h1234, en_mask=4'hF, dp_in=4'b0100 before a boundary.
   - From the boundary, slot 0: 2 clocks an=F, then 6 clocks an=E, seg=19.
   - Slot 1: an=D, seg=30. Slot 2: an=B, seg=24, dp=0. Slot 3: an=7, seg=79.
3. Tear-free update: while slot 2 of a frame showing 16'h1234 is active, load 16'hABCD.
   - Slot 3 still shows 1 (seg=79).
   - The next frame shows D, C, b, A (21, 46, 03, 08).
4. Mask: load en_mask=4'b1010 -> slots 0 and 2 keep an=F for all 8 clocks; slots 1 and 3 assert normally; period stays 32 clocks.
5. Load asserted exactly in the frame_tick cycle with pending staging 16'h1111 -> that frame shows 1111; the new value appears one frame later.
6. rst asserted at cnt=5 of slot 1 -> next cycle an=F, digit_sel=0, shadow cleared; a load issued before rst does not reappear.
